// File: rtl/vga_pkg.sv
// vga_pkg: shared active-area defaults, pattern mode encodings and colour-bar palette
package vga_pkg;
  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;
  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_t;
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;
  function automatic logic [2:0] bar_colour(input logic [2:0] i);
    case (i)
      3'd0: return BAR_WHITE;
      3'd1: return BAR_YELLOW;
      3'd2: return BAR_CYAN;
      3'd3: return BAR_GREEN;
      3'd4: return BAR_MAGENTA;
      3'd5: return BAR_RED;
      3'd6: return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction
endpackage

// File: rtl/vga_pattern_gen_button_debounce.sv
// button_debounce: 2-FF synchronizer, stable-sample counter and one-cycle press pulse for an active-low button
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d;
  // count consecutive samples differing from the accepted level; flip the level once the run is long enough
  always_comb begin
    sync_d = {sync_q[0], btn_n};
    cnt_d = (sync_q[1] != level_q && cnt_q != CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q + CW'(1) : '0;
    level_d = (sync_q[1] != level_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? sync_q[1] : level_q;
    press_d = level_q & ~level_d;
  end
  // state registers, idle means released (high)
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
      cnt_q <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: 2-stage test-pattern colour pipeline with aligned syncs; VGA_BORDER_EN adds a white alignment border
module vga_pattern_gen import vga_pkg::*; #(
  parameter int RGB_BITS        = 4,
  parameter int H_ACTIVE        = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE        = V_ACTIVE_DEFAULT,
  parameter int BOX_SIZE        = 32,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                video_on,
  input  logic                h_sync_in,
  input  logic                v_sync_in,
  input  logic                mode_btn,
  output logic [RGB_BITS-1:0] red,
  output logic [RGB_BITS-1:0] green,
  output logic [RGB_BITS-1:0] blue,
  output logic                h_sync_out,
  output logic                v_sync_out,
  output logic [1:0]          mode
);
  localparam logic [RGB_BITS-1:0] FULL = '1;
  localparam logic [RGB_BITS-1:0] HALF = {1'b1, {(RGB_BITS-1){1'b0}}};
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);
  logic [9:0] x1_q, x1_d, y1_q, y1_d, box_x_q, box_x_d, box_y_q, box_y_d;
  logic von1_q, von1_d, hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [RGB_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  mode_t mode_q, mode_d, pending_q, pending_d;
  logic press, frame, in_box;
  logic [2:0] bar, rgb;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk),
    .rst(rst),
    .btn_n(mode_btn),
    .press(press)
  );
  // stage-1 capture, stage-2 colour, frame-rate box motion and frame-aligned mode switching
  always_comb begin
    x1_d = pixel_x;
    y1_d = pixel_y;
    von1_d = video_on;
    hs1_d = h_sync_in;
    vs1_d = v_sync_in;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    frame = vs2_q & ~vs1_q;
    bar = '0;
    for (int i = 1; i < 8; i++) bar = bar + 3'(x1_q >= 10'(80 * i));
    rgb = bar_colour(bar);
    in_box = x1_q >= box_x_q && {1'b0, x1_q} < {1'b0, box_x_q} + 11'(BOX_SIZE) &&
             y1_q >= box_y_q && {1'b0, y1_q} < {1'b0, box_y_q} + 11'(BOX_SIZE);
    red_d = rgb[2] ? FULL : '0;
    green_d = rgb[1] ? FULL : '0;
    blue_d = rgb[0] ? FULL : '0;
    if (mode_q == MODE_CHECKER) {red_d, green_d, blue_d} = {3*RGB_BITS{x1_q[5] ^ y1_q[5]}};
    else if (mode_q == MODE_GRADIENT) begin
      red_d = RGB_BITS'(x1_q[9:6]) << (RGB_BITS - 4);
      green_d = RGB_BITS'(y1_q[8:5]) << (RGB_BITS - 4);
      blue_d = '0;
    end else if (mode_q == MODE_BOX) begin
      red_d = in_box ? FULL : '0;
      green_d = in_box ? FULL : '0;
      blue_d = in_box ? FULL : HALF;
    end
`ifdef VGA_BORDER_EN
    if (x1_q == 10'd0 || x1_q == 10'(H_ACTIVE - 1) || y1_q == 10'd0 || y1_q == 10'(V_ACTIVE - 1))
      {red_d, green_d, blue_d} = {3{FULL}};
`endif
    if (!von1_q) {red_d, green_d, blue_d} = '0;
    dx_neg_d = frame ? (dx_neg_q ? box_x_q != 10'd0 : box_x_q == X_MAX) : dx_neg_q;
    dy_neg_d = frame ? (dy_neg_q ? box_y_q != 10'd0 : box_y_q == Y_MAX) : dy_neg_q;
    box_x_d = frame ? (dx_neg_d ? box_x_q - 10'd1 : box_x_q + 10'd1) : box_x_q;
    box_y_d = frame ? (dy_neg_d ? box_y_q - 10'd1 : box_y_q + 10'd1) : box_y_q;
    pending_d = press ? mode_t'(pending_q + 2'd1) : pending_q;
    mode_d = frame ? pending_q : mode_q;
  end
  // pipeline and pattern state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      x1_q <= '0;
      y1_q <= '0;
      von1_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      red_q <= '0;
      green_q <= '0;
      blue_q <= '0;
      box_x_q <= '0;
      box_y_q <= '0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      pending_q <= MODE_BARS;
      mode_q <= MODE_BARS;
    end else begin
      x1_q <= x1_d;
      y1_q <= y1_d;
      von1_q <= von1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      red_q <= red_d;
      green_q <= green_d;
      blue_q <= blue_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      pending_q <= pending_d;
      mode_q <= mode_d;
    end
  end
  assign red = red_q;
  assign green = green_q;
  assign blue = blue_q;
  assign h_sync_out = hs2_q;
  assign v_sync_out = vs2_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: randomized directed sequence against a frame-level reference model of the pattern generator
module tb_vga_pattern_gen;
  logic clk = 1'b0, rst = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic video_on = 1'b0, h_sync_in = 1'b1, v_sync_in = 1'b1, mode_btn = 1'b1;
  logic [3:0] red, green, blue;
  logic h_sync_out, v_sync_out;
  logic [1:0] mode;
  int total = 0, bad = 0;
  typedef struct packed {logic [11:0] rgb; logic hs; logic vs; logic [1:0] md;} exp_t;
  exp_t q[$];
  int n_m = 0, pend_m = 0, mode_m = 0;
  bit prev_vs = 1'b1;
  localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  vga_pattern_gen #(.RGB_BITS(4), .H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .mode_btn(mode_btn),
    .red(red), .green(green), .blue(blue), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int bounce(int n, int m);
    int p = n % (2 * m);
    return p <= m ? p : 2 * m - p;
  endfunction

  function automatic logic [11:0] colour(int x, int y, bit von, int md, int n);
    logic [2:0] c;
    int bx = bounce(n, 608), by = bounce(n, 448);
    if (!von) return 12'h000;
`ifdef VGA_BORDER_EN
    if (x == 0 || x == 639 || y == 0 || y == 479) return 12'hfff;
`endif
    if (md == 0) begin
      c = BARS[x / 80];
      return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    end
    if (md == 1) return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 12'hfff : 12'h000;
    if (md == 2) return {4'(x / 64), 4'((y / 32) % 16), 4'h0};
    return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 12'hfff : 12'h008;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int x, int y, bit von, bit hs, bit vs);
    exp_t e;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
      chk("hsync", 32'(h_sync_out), 32'(e.hs));
      chk("vsync", 32'(v_sync_out), 32'(e.vs));
      chk("mode", 32'(mode), 32'(e.md));
    end
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = von;
    h_sync_in = hs;
    v_sync_in = vs;
    e.rgb = colour(x, y, von, mode_m, n_m);
    if (prev_vs && !vs) begin
      n_m++;
      mode_m = pend_m;
    end
    prev_vs = vs;
    e.hs = hs;
    e.vs = vs;
    e.md = 2'(mode_m);
    q.push_back(e);
  endtask

  task automatic blank(int k);
    for (int i = 0; i < k; i++) step(0, 0, 1'b0, rb(), 1'b1);
  endtask

  task automatic frame();
    blank(1);
    step(0, 0, 1'b0, rb(), 1'b0);
    step(0, 0, 1'b0, rb(), 1'b0);
    blank(1);
  endtask

  task automatic rnd_pixels(int k);
    for (int i = 0; i < k; i++)
      step($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3) != 0, rb(), 1'b1);
  endtask

  task automatic btn_low(int k, bit counts);
    mode_btn = 1'b0;
    blank(k);
    mode_btn = 1'b1;
    blank(12);
    if (counts) pend_m = (pend_m + 1) % 4;
  endtask

  task automatic box_probe();
    int bx = bounce(n_m, 608), by = bounce(n_m, 448);
    step(bx, by, 1'b1, rb(), 1'b1);
    step(bx + 31, by + 31, 1'b1, rb(), 1'b1);
    if (bx > 0) step(bx - 1, by + 5, 1'b1, rb(), 1'b1);
    if (bx < 608) step(bx + 32, by + 5, 1'b1, rb(), 1'b1);
    if (by > 0) step(bx + 3, by - 1, 1'b1, rb(), 1'b1);
    if (by < 448) step(bx + 3, by + 32, 1'b1, rb(), 1'b1);
  endtask

  task automatic do_reset();
    exp_t r;
    @(negedge clk);
    rst = 1'b0;
    pixel_x = 10'd100;
    pixel_y = 10'd50;
    video_on = 1'b1;
    h_sync_in = 1'b0;
    v_sync_in = 1'b1;
    @(negedge clk);
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_hsync", 32'(h_sync_out), 32'h1);
    chk("rst_vsync", 32'(v_sync_out), 32'h1);
    chk("rst_mode", 32'(mode), 32'h0);
    rst = 1'b1;
    video_on = 1'b0;
    h_sync_in = 1'b1;
    n_m = 0;
    pend_m = 0;
    mode_m = 0;
    prev_vs = 1'b1;
    r = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, md: 2'd0};
    q.delete();
    q.push_back(r);
    q.push_back(r);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    for (int x = 0; x < 640; x++) step(x, 10, 1'b1, rb(), 1'b1);
    btn_low(3, 1'b0);
    frame();
    rnd_pixels(40);
    btn_low(12, 1'b1);
    frame();
    rnd_pixels(100);
    frame();
    step(32, 0, 1'b1, rb(), 1'b1);
    step(32, 32, 1'b1, rb(), 1'b1);
    step(32, 0, 1'b0, rb(), 1'b1);
    rnd_pixels(100);
    btn_low(12, 1'b1);
    frame();
    rnd_pixels(200);
    btn_low(12, 1'b1);
    btn_low(12, 1'b1);
    frame();
    rnd_pixels(100);
    for (int i = 0; i < 3; i++) btn_low(12, 1'b1);
    frame();
    for (int f = 0; f < 1300; f++) begin
      box_probe();
      frame();
    end
    btn_low(12, 1'b1);
    btn_low(12, 1'b1);
    step(200, 100, 1'b1, rb(), 1'b1);
    do_reset();
    rnd_pixels(20);
    frame();
    rnd_pixels(20);
    btn_low(12, 1'b1);
    frame();
    step(0, 100, 1'b1, rb(), 1'b1);
    step(639, 200, 1'b1, rb(), 1'b1);
    step(300, 0, 1'b1, rb(), 1'b1);
    step(300, 479, 1'b1, rb(), 1'b1);
    step(1, 1, 1'b1, rb(), 1'b1);
    blank(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
